// File: rtl/dcache_assoc_mem_pkg.sv
// Shared definitions for the set-associative D-cache storage: bus command
// encodings, the flush FSM state type and the way-index width helper.
package dcache_assoc_mem_pkg;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef enum logic [1:0] {
      FL_IDLE,
      FL_SCAN,
      FL_REQ,
      FL_HALTED
   } flush_state_t;

   // A single-way cache still needs a 1-bit way index.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/dcache_way_select.sv
// Resolves the way a write port targets: tag hit in place, else the
// lowest-numbered invalid way, else the set's round-robin pointer way.
module dcache_way_select
   import dcache_assoc_mem_pkg::*;
#(
   parameter int NUM_WAYS = 2,
   parameter int TAG_W    = 22,
   parameter int WAY_W    = 1
) (
   input  logic [NUM_WAYS-1:0]            valid,
   input  logic [NUM_WAYS-1:0][TAG_W-1:0] tags,
   input  logic [TAG_W-1:0]               tag,
   input  logic [WAY_W-1:0]               rr_ptr,
   output logic [WAY_W-1:0]               way,
   output logic                           hit,
   output logic                           use_rr
);

   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] inv_way;
   logic             have_inv;

   // Descending walk so the lowest-numbered candidate is the one kept.
   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      have_inv = 1'b0;
      inv_way  = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid[w] && (tags[w] == tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid[w]) begin
            have_inv = 1'b1;
            inv_way  = WAY_W'(w);
         end
      end
      use_rr = !hit && !have_inv;
      way    = hit ? hit_way : (have_inv ? inv_way : rr_ptr);
   end

endmodule

// File: rtl/dcache_assoc_mem.sv
// Set-associative D-cache tag/data/valid/dirty storage with fill/store ports,
// dirty-victim eviction and a halt-time flush FSM. Statistics counters are
// built only when DCACHE_STATS_EN is defined.
//
// state     | meaning
// FL_IDLE   | normal operation, writes accepted
// FL_SCAN   | walking (set,way) looking for dirty lines
// FL_REQ    | BUS_STORE of current dirty line until mem_response != 0
// FL_HALTED | flush done, halt_complete held until reset
module dcache_assoc_mem
   import dcache_assoc_mem_pkg::*;
#(
   parameter int NUM_SETS = 64,
   parameter int NUM_WAYS = 2,
   parameter int TAG_W    = 22,
   parameter int DATA_W   = 64,
   localparam int IDX_W   = $clog2(NUM_SETS),
   localparam int WAY_W   = way_bits(NUM_WAYS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_hit,
   input  logic              wr1_en,
   input  logic [IDX_W-1:0]  wr1_idx,
   input  logic [TAG_W-1:0]  wr1_tag,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic              wr0_en,
   input  logic [IDX_W-1:0]  wr0_idx,
   input  logic [TAG_W-1:0]  wr0_tag,
   input  logic [DATA_W-1:0] wr0_data,
   output logic              evict_valid,
   output logic [63:0]       evict_addr,
   output logic [DATA_W-1:0] evict_data,
   input  logic              dcache_halt,
   output logic [1:0]        mem_cmd,
   output logic [63:0]       mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic [3:0]        mem_response,
   output logic              busy,
   output logic              halt_complete,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   logic [NUM_WAYS-1:0][TAG_W-1:0] tag_mem   [NUM_SETS];
   logic [DATA_W-1:0]              data_mem  [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0]            valid_mem [NUM_SETS];
   logic [NUM_WAYS-1:0]            dirty_mem [NUM_SETS];
   logic [WAY_W-1:0]               rr_ptr    [NUM_SETS];

   flush_state_t     state, next_state;
   logic [IDX_W-1:0] scan_set;
   logic [WAY_W-1:0] scan_way;
   logic             advance, clear_dirty, last_line, cur_dirty;

   logic [WAY_W-1:0] way0, way1;
   logic             hit0, hit1, rr0, rr1, same_way, do0, do1;

   function automatic logic [63:0] line_addr(input logic [TAG_W-1:0] t,
                                             input logic [IDX_W-1:0] i);
      return 64'({t, i, 3'b000});
   endfunction

   function automatic logic [WAY_W-1:0] next_ptr(input logic [WAY_W-1:0] p);
      return (p == WAY_W'(NUM_WAYS - 1)) ? '0 : p + WAY_W'(1);
   endfunction

   always_comb begin
      rd_hit  = 1'b0;
      rd_data = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_mem[rd_idx][w] && (tag_mem[rd_idx][w] == rd_tag)) begin
            rd_hit  = 1'b1;
            rd_data = data_mem[rd_idx][w];
         end
      end
   end

   dcache_way_select #(.NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_sel1 (
      .valid  (valid_mem[wr1_idx]),
      .tags   (tag_mem[wr1_idx]),
      .tag    (wr1_tag),
      .rr_ptr (rr_ptr[wr1_idx]),
      .way    (way1),
      .hit    (hit1),
      .use_rr (rr1)
   );

   dcache_way_select #(.NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_sel0 (
      .valid  (valid_mem[wr0_idx]),
      .tags   (tag_mem[wr0_idx]),
      .tag    (wr0_tag),
      .rr_ptr (rr_ptr[wr0_idx]),
      .way    (way0),
      .hit    (hit0),
      .use_rr (rr0)
   );

   // A fill and a store landing on the same line: the fill wins.
   assign same_way = (wr0_idx == wr1_idx) && (way0 == way1);
   assign do1      = wr1_en && (state == FL_IDLE);
   assign do0      = wr0_en && (state == FL_IDLE) && !(do1 && same_way);

   assign evict_valid = do1 && valid_mem[wr1_idx][way1] && dirty_mem[wr1_idx][way1];
   assign evict_addr  = line_addr(tag_mem[wr1_idx][way1], wr1_idx);
   assign evict_data  = data_mem[wr1_idx][way1];

   always_ff @(posedge clock) begin
      if (do0) begin
         data_mem[wr0_idx][way0] <= wr0_data;
         tag_mem[wr0_idx][way0]  <= wr0_tag;
      end
      if (do1) begin
         data_mem[wr1_idx][way1] <= wr1_data;
         tag_mem[wr1_idx][way1]  <= wr1_tag;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_mem[s] <= '0;
            dirty_mem[s] <= '0;
            rr_ptr[s]    <= '0;
         end
      end else begin
         if (do0) begin
            valid_mem[wr0_idx][way0] <= 1'b1;
            dirty_mem[wr0_idx][way0] <= 1'b1;
         end
         if (do1) begin
            valid_mem[wr1_idx][way1] <= 1'b1;
            dirty_mem[wr1_idx][way1] <= 1'b0;
         end
         if (clear_dirty)
            dirty_mem[scan_set][scan_way] <= 1'b0;
         if (do1 && rr1)
            rr_ptr[wr1_idx] <= next_ptr(rr_ptr[wr1_idx]);
         if (do0 && rr0 && !(do1 && rr1 && (wr0_idx == wr1_idx)))
            rr_ptr[wr0_idx] <= next_ptr(rr_ptr[wr0_idx]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= FL_IDLE;
         scan_set <= '0;
         scan_way <= '0;
      end else begin
         state <= next_state;
         if (state == FL_IDLE) begin
            scan_set <= '0;
            scan_way <= '0;
         end else if (advance) begin
            if (scan_way == WAY_W'(NUM_WAYS - 1)) begin
               scan_way <= '0;
               scan_set <= scan_set + IDX_W'(1);
            end else begin
               scan_way <= scan_way + WAY_W'(1);
            end
         end
      end
   end

   assign last_line = (scan_set == IDX_W'(NUM_SETS - 1)) && (scan_way == WAY_W'(NUM_WAYS - 1));
   assign cur_dirty = valid_mem[scan_set][scan_way] && dirty_mem[scan_set][scan_way];
   assign mem_addr  = line_addr(tag_mem[scan_set][scan_way], scan_set);
   assign mem_data  = data_mem[scan_set][scan_way];

   always_comb begin
      next_state    = state;
      advance       = 1'b0;
      clear_dirty   = 1'b0;
      mem_cmd       = BUS_NONE;
      busy          = 1'b0;
      halt_complete = 1'b0;
      case (state)
         FL_IDLE: if (dcache_halt) next_state = FL_SCAN;
         FL_SCAN: begin
            busy = 1'b1;
            if (cur_dirty) begin
               next_state = FL_REQ;
            end else begin
               advance    = 1'b1;
               next_state = last_line ? FL_HALTED : FL_SCAN;
            end
         end
         FL_REQ: begin
            busy    = 1'b1;
            mem_cmd = BUS_STORE;
            if (|mem_response) begin
               clear_dirty = 1'b1;
               advance     = 1'b1;
               next_state  = last_line ? FL_HALTED : FL_SCAN;
            end
         end
         FL_HALTED: halt_complete = 1'b1;
         default:   next_state = FL_IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (rd_en) begin
         if (rd_hit) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
         end else begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
         end
      end
   end
`else
   logic unused_rd_en;
   assign unused_rd_en = rd_en;
   assign hit_count    = '0;
   assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_dcache_assoc_mem.sv
// Directed self-checking bench for dcache_assoc_mem (default 64 sets x 2 ways).
module tb_dcache_assoc_mem;
   import dcache_assoc_mem_pkg::*;

   localparam int TAG_W  = 22;
   localparam int DATA_W = 64;
   localparam int IDX_W  = 6;

   logic              clock = 1'b0;
   logic              reset;
   logic              rd_en;
   logic [IDX_W-1:0]  rd_idx;
   logic [TAG_W-1:0]  rd_tag;
   logic [DATA_W-1:0] rd_data;
   logic              rd_hit;
   logic              wr1_en, wr0_en;
   logic [IDX_W-1:0]  wr1_idx, wr0_idx;
   logic [TAG_W-1:0]  wr1_tag, wr0_tag;
   logic [DATA_W-1:0] wr1_data, wr0_data;
   logic              evict_valid;
   logic [63:0]       evict_addr;
   logic [DATA_W-1:0] evict_data;
   logic              dcache_halt;
   logic [1:0]        mem_cmd;
   logic [63:0]       mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [3:0]        mem_response;
   logic              busy, halt_complete;
   logic [31:0]       hit_count, miss_count;

   int checks   = 0;
   int failures = 0;

   dcache_assoc_mem dut (
      .clock(clock), .reset(reset),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data), .rd_hit(rd_hit),
      .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_tag(wr1_tag), .wr1_data(wr1_data),
      .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_tag(wr0_tag), .wr0_data(wr0_data),
      .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
      .dcache_halt(dcache_halt), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_response(mem_response), .busy(busy), .halt_complete(halt_complete),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic lookup(input int idx, input int tag);
      rd_idx = IDX_W'(idx);
      rd_tag = TAG_W'(tag);
      #1;
   endtask

   task automatic fill(input int idx, input int tag, input logic [63:0] data);
      wr1_en = 1'b1; wr1_idx = IDX_W'(idx); wr1_tag = TAG_W'(tag); wr1_data = data;
      tick;
      wr1_en = 1'b0;
   endtask

   task automatic store(input int idx, input int tag, input logic [63:0] data);
      wr0_en = 1'b1; wr0_idx = IDX_W'(idx); wr0_tag = TAG_W'(tag); wr0_data = data;
      tick;
      wr0_en = 1'b0;
   endtask

   task automatic halt_pulse;
      dcache_halt = 1'b1;
      tick;
      dcache_halt = 1'b0;
   endtask

   task automatic wait_store(output int cycles);
      cycles = 0;
      while (mem_cmd !== BUS_STORE && cycles < 200) begin
         tick;
         cycles++;
      end
   endtask

   initial begin
      int n;
      int extra;
      logic [63:0] held_addr;

      reset = 1'b1; rd_en = 1'b0; rd_idx = '0; rd_tag = '0;
      wr1_en = 1'b0; wr1_idx = '0; wr1_tag = '0; wr1_data = '0;
      wr0_en = 1'b0; wr0_idx = '0; wr0_tag = '0; wr0_data = '0;
      dcache_halt = 1'b0; mem_response = '0;
      tick; tick;
      reset = 1'b0;
      #1;

      check("rst_mem_cmd", 64'(mem_cmd), 64'(BUS_NONE));
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_halt_complete", 64'(halt_complete), 64'd0);
      check("rst_hit_count", 64'(hit_count), 64'd0);
      check("rst_miss_count", 64'(miss_count), 64'd0);
      lookup(5, 'h10);
      check("rst_rd_hit", 64'(rd_hit), 64'd0);

      // Basic fill then lookup
      fill(5, 'h10, 64'hAA);
      lookup(5, 'h10);
      check("t1_hit", 64'(rd_hit), 64'd1);
      check("t1_data", rd_data, 64'hAA);
      lookup(5, 'h11);
      check("t1_other_tag_hit", 64'(rd_hit), 64'd0);
      check("t1_miss_data", rd_data, 64'd0);

      // Round-robin replacement in set 3
      fill(3, 1, 64'h101);
      fill(3, 2, 64'h102);
      fill(3, 3, 64'h103);
      lookup(3, 1); check("t2_tag1_evicted", 64'(rd_hit), 64'd0);
      lookup(3, 2); check("t2_tag2_hit", 64'(rd_hit), 64'd1);
      check("t2_tag2_data", rd_data, 64'h102);
      lookup(3, 3); check("t2_tag3_hit", 64'(rd_hit), 64'd1);
      check("t2_tag3_data", rd_data, 64'h103);

      // Dirty store to way 1, then a fill that must pick pointer way 1
      store(3, 2, 64'h55);
      wr1_en = 1'b1; wr1_idx = 6'd3; wr1_tag = 22'd7; wr1_data = 64'h77;
      #1;
      check("t3_evict_valid", 64'(evict_valid), 64'd1);
      check("t3_evict_addr", evict_addr, 64'h418);
      check("t3_evict_data", evict_data, 64'h55);
      tick;
      wr1_en = 1'b0;
      lookup(3, 7); check("t3_tag7_hit", 64'(rd_hit), 64'd1);
      check("t3_tag7_data", rd_data, 64'h77);
      lookup(3, 2); check("t3_tag2_gone", 64'(rd_hit), 64'd0);
      lookup(3, 3); check("t3_tag3_kept", 64'(rd_hit), 64'd1);
      // Pointer now at way 0 holding clean tag 3: no eviction report
      wr1_en = 1'b1; wr1_idx = 6'd3; wr1_tag = 22'd8; wr1_data = 64'h88;
      #1;
      check("t3_clean_evict", 64'(evict_valid), 64'd0);
      tick;
      wr1_en = 1'b0;
      lookup(3, 3); check("t3_tag3_evicted", 64'(rd_hit), 64'd0);

      // Simultaneous store and fill to the same line
      wr0_en = 1'b1; wr0_idx = 6'd9; wr0_tag = 22'h20; wr0_data = 64'h1111;
      wr1_en = 1'b1; wr1_idx = 6'd9; wr1_tag = 22'h20; wr1_data = 64'h2222;
      tick;
      wr0_en = 1'b0; wr1_en = 1'b0;
      lookup(9, 'h20);
      check("t4_hit", 64'(rd_hit), 64'd1);
      check("t4_fill_wins", rd_data, 64'h2222);

      // Flush with two dirty lines
      store(2, 5, 64'hD1);
      store(10, 6, 64'hD2);
      halt_pulse;
      check("t5_busy", 64'(busy), 64'd1);
      wait_store(n);
      check("t5_st1_cmd", 64'(mem_cmd), 64'(BUS_STORE));
      check("t5_st1_addr", mem_addr, 64'hA10);
      check("t5_st1_data", mem_data, 64'hD1);
      held_addr = mem_addr;
      for (int k = 0; k < 3; k++) begin
         tick;
         check("t5_st1_hold_cmd", 64'(mem_cmd), 64'(BUS_STORE));
         check("t5_st1_hold_addr", mem_addr, held_addr);
      end
      mem_response = 4'h1;
      tick;
      mem_response = 4'h0;
      check("t5_st1_released", 64'(mem_cmd), 64'(BUS_NONE));
      wait_store(n);
      check("t5_st2_cmd", 64'(mem_cmd), 64'(BUS_STORE));
      check("t5_st2_addr", mem_addr, 64'hC50);
      check("t5_st2_data", mem_data, 64'hD2);
      mem_response = 4'h2;
      tick;
      mem_response = 4'h0;
      n = 0; extra = 0;
      while (halt_complete !== 1'b1 && n < 400) begin
         if (mem_cmd === BUS_STORE) extra++;
         tick;
         n++;
      end
      check("t5_halt_complete", 64'(halt_complete), 64'd1);
      check("t5_busy_done", 64'(busy), 64'd0);
      check("t5_extra_stores", 64'(extra), 64'd0);
      tick; tick; tick;
      check("t5_halt_sticky", 64'(halt_complete), 64'd1);
      fill(20, 1, 64'h99);
      lookup(20, 1); check("t5_fill_ignored", 64'(rd_hit), 64'd0);
      halt_pulse;
      check("t5_halt_ignored", 64'(busy), 64'd0);

      // Reset in the middle of a store request
      reset = 1'b1; tick; reset = 1'b0;
      store(4, 9, 64'hBEEF);
      halt_pulse;
      wait_store(n);
      check("t6_in_req", 64'(mem_cmd), 64'(BUS_STORE));
      check("t6_req_addr", mem_addr, 64'h1220);
      reset = 1'b1;
      tick;
      check("t6_cmd_none", 64'(mem_cmd), 64'(BUS_NONE));
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_halt_complete", 64'(halt_complete), 64'd0);
      reset = 1'b0;
      lookup(4, 9); check("t6_line_invalid", 64'(rd_hit), 64'd0);
      lookup(9, 'h20); check("t6_old_line_invalid", 64'(rd_hit), 64'd0);

      // Statistics: 3 hits, 2 misses
      fill(1, 'h33, 64'h3333);
      rd_en = 1'b1;
      lookup(1, 'h33); tick; tick; tick;
      lookup(1, 'h34); tick; tick;
      rd_en = 1'b0;
      #1;
`ifdef DCACHE_STATS_EN
      check("stats_hits", 64'(hit_count), 64'd3);
      check("stats_misses", 64'(miss_count), 64'd2);
`else
      check("stats_hits_off", 64'(hit_count), 64'd0);
      check("stats_misses_off", 64'(miss_count), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
